// File: rtl/spi_engine.sv
// spi_engine: byte-wide SPI master shift engine, mode 0 (CPOL=0, CPHA=0), MSB first.
// The engine accepts a start request in IDLE and shifts out the TX byte on MOSI.
// It captures MISO on every SCLK rising edge and reports the received byte on completion.
// SCLK half-period is CLK_DIV raw_clk cycles. CLK_DIV must be in 1..255.
module spi_engine #(
    parameter logic [7:0] CLK_DIV = 8'd4
) (
    input  logic       raw_clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [7:0] data_tx_i,
    output logic [7:0] data_rx_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       sclk_o,
    output logic       mosi_o,
    input  logic       miso_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] div_cnt_q, div_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] data_rx_q, data_rx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       div_last_s;

    // The current SCLK half-period ends on this cycle's edge.
    assign div_last_s = (div_cnt_q == (CLK_DIV - 8'd1));

    // Next-state and output logic of the shift engine.
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        data_rx_d  = data_rx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        case (state_q)
            ST_IDLE: begin
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                busy_d = 1'b0;
                if (start_i) begin
                    state_d    = ST_LOW;
                    tx_shift_d = data_tx_i;
                    mosi_d     = data_tx_i[7];
                    bit_cnt_d  = 3'd0;
                    div_cnt_d  = 8'd0;
                    busy_d     = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (div_last_s) begin
                    // Rising SCLK edge: MISO is captured on this same edge.
                    state_d    = ST_HIGH;
                    sclk_d     = 1'b1;
                    rx_shift_d = {rx_shift_q[6:0], miso_i};
                    div_cnt_d  = 8'd0;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            ST_HIGH: begin
                if (div_last_s) begin
                    sclk_d    = 1'b0;
                    div_cnt_d = 8'd0;
                    if (bit_cnt_q != 3'd7) begin
                        // Falling SCLK edge: present the next bit while SCLK is low.
                        state_d    = ST_LOW;
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        mosi_d     = tx_shift_q[6];
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                    end else begin
                        state_d   = ST_IDLE;
                        mosi_d    = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        data_rx_d = rx_shift_q;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; reset discards any partial byte.
    always_ff @(posedge raw_clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= 8'd0;
            bit_cnt_q  <= 3'd0;
            tx_shift_q <= 8'd0;
            rx_shift_q <= 8'd0;
            data_rx_q  <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            data_rx_q  <= data_rx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
        end
    end

    assign data_rx_o = data_rx_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;

endmodule

// File: tb/tb_spi_engine.sv
// Testbench for spi_engine: three instances with CLK_DIV = 2, 4 and 1 share one clock.
// A cycle-offset model predicts every output each cycle, and directed tests pin literal results.
module tb_spi_engine;

    logic       clk;
    logic [2:0] rst, st, loop, miso_drv;
    logic [7:0] dtx [3];
    logic [7:0] drx [3];
    logic [2:0] busy, done, sclk, mosi, miso_w;
    logic       chk_en;
    int         n_run, n_fail;

    assign miso_w = (loop & mosi) | (~loop & miso_drv);

    spi_engine #(.CLK_DIV(8'd2)) u_d2 (
        .raw_clk_i(clk), .reset_i(rst[0]), .start_i(st[0]), .data_tx_i(dtx[0]),
        .data_rx_o(drx[0]), .busy_o(busy[0]), .done_o(done[0]), .sclk_o(sclk[0]),
        .mosi_o(mosi[0]), .miso_i(miso_w[0]));
    spi_engine #(.CLK_DIV(8'd4)) u_d4 (
        .raw_clk_i(clk), .reset_i(rst[1]), .start_i(st[1]), .data_tx_i(dtx[1]),
        .data_rx_o(drx[1]), .busy_o(busy[1]), .done_o(done[1]), .sclk_o(sclk[1]),
        .mosi_o(mosi[1]), .miso_i(miso_w[1]));
    spi_engine #(.CLK_DIV(8'd1)) u_d1 (
        .raw_clk_i(clk), .reset_i(rst[2]), .start_i(st[2]), .data_tx_i(dtx[2]),
        .data_rx_o(drx[2]), .busy_o(busy[2]), .done_o(done[2]), .sclk_o(sclk[2]),
        .mosi_o(mosi[2]), .miso_i(miso_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int divof(input int i);
        case (i)
            0:       return 2;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a transfer is described only by its offset (edges since acceptance).
    logic       exp_b [3];
    logic       exp_d [3];
    logic       exp_s [3];
    logic       exp_m [3];
    logic [7:0] exp_rx [3];
    logic [7:0] m_tx [3];
    logic [7:0] m_rx [3];
    int         m_off [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            exp_b[i] = 1'b0; exp_d[i] = 1'b0; exp_s[i] = 1'b0; exp_m[i] = 1'b0;
            exp_rx[i] = 8'h00; m_tx[i] = 8'h00; m_rx[i] = 8'h00; m_off[i] = 0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                int d;
                d = divof(i);
                if (rst[i]) begin
                    exp_b[i] = 1'b0; exp_d[i] = 1'b0; exp_s[i] = 1'b0;
                    exp_m[i] = 1'b0; exp_rx[i] = 8'h00;
                end else if (!exp_b[i]) begin
                    exp_d[i] = 1'b0; exp_s[i] = 1'b0; exp_m[i] = 1'b0;
                    if (st[i]) begin
                        exp_b[i] = 1'b1; m_off[i] = 0; m_tx[i] = dtx[i];
                        exp_m[i] = dtx[i][7];
                    end
                end else begin
                    m_off[i]++;
                    if (m_off[i] % (2 * d) == d) m_rx[i] = {m_rx[i][6:0], miso_w[i]};
                    if (m_off[i] == 16 * d) begin
                        exp_b[i] = 1'b0; exp_d[i] = 1'b1; exp_s[i] = 1'b0;
                        exp_m[i] = 1'b0; exp_rx[i] = m_rx[i];
                    end else begin
                        exp_s[i] = ((m_off[i] / d) % 2) == 1;
                        exp_m[i] = m_tx[i][7 - m_off[i] / (2 * d)];
                    end
                end
            end
        end
    end

    // Compare every output of every instance against the model on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("busy[%0d]", i), {31'd0, busy[i]}, {31'd0, exp_b[i]});
                    chk($sformatf("done[%0d]", i), {31'd0, done[i]}, {31'd0, exp_d[i]});
                    chk($sformatf("sclk[%0d]", i), {31'd0, sclk[i]}, {31'd0, exp_s[i]});
                    chk($sformatf("mosi[%0d]", i), {31'd0, mosi[i]}, {31'd0, exp_m[i]});
                    chk($sformatf("data_rx[%0d]", i), {24'd0, drx[i]}, {24'd0, exp_rx[i]});
                end
            end
        end
    end

    task automatic xfer(input int i, input logic [7:0] b, input int repulse,
                        output int busy_n, output int rises, output int hi_n,
                        output logic [7:0] mseq, output int done_n);
        logic prev;
        int   win;
        win = 16 * divof(i) + 4;
        busy_n = 0; rises = 0; hi_n = 0; mseq = 8'h00; done_n = 0; prev = 1'b0;
        @(negedge clk);
        dtx[i] = b;
        st[i]  = 1'b1;
        for (int c = 0; c < win; c++) begin
            @(negedge clk);
            if (c == 0) st[i] = 1'b0;
            if (repulse > 0 && c == repulse) begin st[i] = 1'b1; dtx[i] = 8'h11; end
            if (repulse > 0 && c == repulse + 1) st[i] = 1'b0;
            if (busy[i]) busy_n++;
            if (sclk[i]) hi_n++;
            if (sclk[i] && !prev) begin rises++; mseq = {mseq[6:0], mosi[i]}; end
            prev = sclk[i];
            if (done[i]) done_n++;
        end
    endtask

    int         bn, rn, hn, dn, nd;
    int         dcyc [2];
    logic [7:0] ms;
    logic [7:0] rxs [2];

    initial begin
        n_run = 0; n_fail = 0; chk_en = 1'b0;
        rst = 3'b111; st = 3'b000; loop = 3'b000; miso_drv = 3'b000;
        for (int i = 0; i < 3; i++) dtx[i] = 8'h00;
        @(negedge clk); @(negedge clk);
        chk_en = 1'b1;
        chk("reset_busy", {29'd0, busy}, 32'd0);
        chk("reset_sclk_mosi", {26'd0, sclk, mosi}, 32'd0);
        chk("reset_rx", {24'd0, drx[1]}, 32'h00);
        rst = 3'b000;

        // CLK_DIV=2, loopback, 0xA5
        loop[0] = 1'b1;
        xfer(0, 8'hA5, 0, bn, rn, hn, ms, dn);
        chk("a5_rx", {24'd0, drx[0]}, 32'hA5);
        chk("a5_done_n", dn, 32'd1);
        chk("a5_busy_n", bn, 32'd32);
        chk("a5_rises", rn, 32'd8);
        chk("a5_hi_n", hn, 32'd16);
        chk("a5_mosi", {24'd0, ms}, 32'hA5);

        // CLK_DIV=4, 0x3C with miso held 0, then held 1
        miso_drv[1] = 1'b0;
        xfer(1, 8'h3C, 0, bn, rn, hn, ms, dn);
        chk("3c_rx0", {24'd0, drx[1]}, 32'h00);
        chk("3c_mosi", {24'd0, ms}, 32'h3C);
        chk("3c_busy_n", bn, 32'd64);
        miso_drv[1] = 1'b1;
        xfer(1, 8'h3C, 0, bn, rn, hn, ms, dn);
        chk("3c_rx1", {24'd0, drx[1]}, 32'hFF);
        chk("3c_rises", rn, 32'd8);

        // Start re-pulsed mid-transfer with a different byte: ignored
        xfer(0, 8'hC3, 4, bn, rn, hn, ms, dn);
        chk("repulse_done_n", dn, 32'd1);
        chk("repulse_rx", {24'd0, drx[0]}, 32'hC3);
        chk("repulse_mosi", {24'd0, ms}, 32'hC3);
        chk("repulse_busy_n", bn, 32'd32);

        // Reset at N+3*CLK_DIV on the CLK_DIV=4 instance
        loop[1] = 1'b1;
        @(negedge clk);
        dtx[1] = 8'h96; st[1] = 1'b1;
        @(negedge clk);
        st[1] = 1'b0;
        chk("rst_accept", {31'd0, busy[1]}, 32'd1);
        for (int c = 1; c < 12; c++) @(negedge clk);
        chk("rst_pre_rx", {24'd0, drx[1]}, 32'hFF);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        chk("rst_busy", {31'd0, busy[1]}, 32'd0);
        chk("rst_sclk", {31'd0, sclk[1]}, 32'd0);
        chk("rst_mosi", {31'd0, mosi[1]}, 32'd0);
        chk("rst_rx", {24'd0, drx[1]}, 32'h00);
        chk("rst_done", {31'd0, done[1]}, 32'd0);
        xfer(1, 8'h5A, 0, bn, rn, hn, ms, dn);
        chk("post_rst_rx", {24'd0, drx[1]}, 32'h5A);
        chk("post_rst_done_n", dn, 32'd1);

        // CLK_DIV=1, start held high: back-to-back 0x81 then 0x7E
        loop[2] = 1'b1;
        @(negedge clk);
        dtx[2] = 8'h81; st[2] = 1'b1;
        nd = 0; dcyc[0] = 0; dcyc[1] = 0; rxs[0] = 8'h00; rxs[1] = 8'h00;
        for (int c = 0; c < 60 && nd < 2; c++) begin
            @(negedge clk);
            if (c == 3) dtx[2] = 8'h7E;
            if (nd == 1 && c == dcyc[0] + 1) chk("b2b_rise", {31'd0, busy[2]}, 32'd1);
            if (done[2]) begin
                chk("b2b_gap", {31'd0, busy[2]}, 32'd0);
                dcyc[nd] = c; rxs[nd] = drx[2]; nd++;
                if (nd == 2) st[2] = 1'b0;
            end
        end
        st[2] = 1'b0;
        chk("b2b_count", nd, 32'd2);
        chk("b2b_first", dcyc[0], 32'd16);
        chk("b2b_period", dcyc[1] - dcyc[0], 32'd17);
        chk("b2b_rx0", {24'd0, rxs[0]}, 32'h81);
        chk("b2b_rx1", {24'd0, rxs[1]}, 32'h7E);

        // Reset and start in the same cycle: reset wins
        @(negedge clk); @(negedge clk);
        rst[2] = 1'b1; st[2] = 1'b1; dtx[2] = 8'hFF;
        @(negedge clk);
        rst[2] = 1'b0; st[2] = 1'b0;
        hn = 0; bn = 0;
        for (int c = 0; c < 4; c++) begin
            if (busy[2]) bn++;
            if (sclk[2]) hn++;
            @(negedge clk);
        end
        chk("rs_busy", bn, 32'd0);
        chk("rs_sclk", hn, 32'd0);
        chk("rs_rx", {24'd0, drx[2]}, 32'h00);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
